md_unit_param: RTL and testbench

//   Parametrised multi-cycle multiply/divide unit for the E stage of the pipelined CPU.

---
 rtl/md_unit_param.sv | 198 +++++++++++++++++++
 tb/tb_md_unit_param.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/md_unit_param.sv
// md_unit_param
//   Multi-cycle multiply/divide unit for the E stage. The result is computed
//   from the operands (and HI/LO for the accumulate ops) on the accept edge
//   and parked in a pending register. A down-counter then holds busy for the
//   configured latency before HI/LO are written. The previous {hi,lo} is kept
//   in a one-level backup, so an exception can roll the last commit back.
//
//   Ports
//     clk      clock, rising edge
//     rst      synchronous reset, active high
//     op       operation code (0 NOP .. 10 MSUBU, 11..15 invalid)
//     dh, dl   operands A/B; dh is also the MTHI/MTLO data
//     stop     suppress issue this cycle / abort an in-flight op
//     restore  {hi,lo} <= backup; also aborts an in-flight op
//     busy     op in flight (control stalls on this)
//     invalid  op code 11..15 presented this cycle (combinational)
//     hi, lo   HI/LO registers
//
//   state  | meaning
//   S_IDLE | accepting ops; MTHI/MTLO complete in a single edge
//   S_RUN  | long op in flight; counter counts down to the commit edge
module md_unit_param #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] dh,
    input  logic [WIDTH-1:0] dl,
    input  logic             stop,
    input  logic             restore,
    output logic             busy,
    output logic             invalid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic [2*WIDTH-1:0]     backup_q, backup_d;
    logic [2*WIDTH-1:0]     pend_q, pend_d;
    logic                   dz_q, dz_d;

    logic [2*WIDTH-1:0]     hilo;
    logic [2*WIDTH-1:0]     a_sx, b_sx, a_zx, b_zx;
    logic [2*WIDTH-1:0]     prod_s, prod_u;
    logic                   is_div, is_long, div_zero;
    logic                   a_neg, b_neg;
    logic [WIDTH-1:0]       a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
    logic [2*WIDTH-1:0]     result;

    assign hilo = {hi_q, lo_q};

    // A 2W x 2W multiply of the sign-extended operands yields the signed
    // product in its low 2W bits, so one multiplier form serves both cases.
    assign a_sx   = {{WIDTH{dh[WIDTH-1]}}, dh};
    assign b_sx   = {{WIDTH{dl[WIDTH-1]}}, dl};
    assign a_zx   = {{WIDTH{1'b0}}, dh};
    assign b_zx   = {{WIDTH{1'b0}}, dl};
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;

    // Signed division is done on magnitudes and the signs are patched back:
    // quotient truncates toward zero, remainder follows the dividend.
    // MIN / -1 falls out naturally as quotient MIN, remainder 0.
    assign is_div   = (op == OP_DIV) || (op == OP_DIVU);
    assign div_zero = (dl == '0);
    assign a_neg    = (op == OP_DIV) && dh[WIDTH-1];
    assign b_neg    = (op == OP_DIV) && dl[WIDTH-1];
    assign a_mag    = a_neg ? -dh : dh;
    assign b_mag    = b_neg ? -dl : dl;
    // Keep the divider away from a zero divisor; that result is never committed.
    assign b_safe   = div_zero ? WIDTH'(1) : b_mag;
    assign q_mag    = a_mag / b_safe;
    assign r_mag    = a_mag % b_safe;
    assign quo      = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem      = a_neg ? -r_mag : r_mag;

    always_comb begin
        result  = '0;
        is_long = 1'b1;
        case (op)
            OP_MULT:           result = prod_s;
            OP_MULTU:          result = prod_u;
            OP_DIV, OP_DIVU:   result = {rem, quo};
            OP_MADD:           result = hilo + prod_s;
            OP_MADDU:          result = hilo + prod_u;
            OP_MSUB:           result = hilo - prod_s;
            OP_MSUBU:          result = hilo - prod_u;
            default:           is_long = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        backup_d = backup_q;
        pend_d   = pend_q;
        dz_d     = dz_q;

        if (restore) begin
            // Rollback outranks everything, including an in-flight op.
            {hi_d, lo_d} = backup_q;
            state_d      = S_IDLE;
            cnt_d        = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!stop) begin
                        if (is_long) begin
                            pend_d  = result;
                            dz_d    = is_div && div_zero;
                            cnt_d   = is_div ? DIV_LOAD : MUL_LOAD;
                            state_d = S_RUN;
                        end else if (op == OP_MTHI) begin
                            backup_d = hilo;
                            hi_d     = dh;
                        end else if (op == OP_MTLO) begin
                            backup_d = hilo;
                            lo_d     = dh;
                        end
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == '0) begin
                        state_d = S_IDLE;
                        if (!dz_q) begin
                            backup_d     = hilo;
                            {hi_d, lo_d} = pend_q;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            backup_q <= '0;
            pend_q   <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            backup_q <= backup_d;
            pend_q   <= pend_d;
            dz_q     <= dz_d;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign invalid = (op > OP_MSUBU);
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_md_unit_param.sv
module tb_md_unit_param;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, stop, restore;
    logic [3:0]   op;
    logic [W-1:0] dh, dl;
    logic         busy, invalid;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    md_unit_param #(.WIDTH(W), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .op(op), .dh(dh), .dl(dl), .stop(stop),
        .restore(restore), .busy(busy), .invalid(invalid), .hi(hi), .lo(lo)
    );

    typedef struct {
        string        name;
        logic [3:0]   op;
        logic [W-1:0] pre_hi, pre_lo, a, b;
        int           cycles;
        logic [W-1:0] exp_hi, exp_lo;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string name, input logic [3:0] o,
                                input logic [W-1:0] ph, input logic [W-1:0] pl,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input int cyc, input logic [W-1:0] eh, input logic [W-1:0] el);
        vec_t v;
        v.name = name; v.op = o; v.pre_hi = ph; v.pre_lo = pl; v.a = a; v.b = b;
        v.cycles = cyc; v.exp_hi = eh; v.exp_lo = el;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hilo(input logic [W-1:0] h, input logic [W-1:0] l);
        op = 4'd5; dh = h; tick();
        op = 4'd6; dh = l; tick();
        op = 4'd0; dh = '0;
    endtask

    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op = o; dh = a; dl = b; tick();
        op = 4'd0; dh = '0; dl = '0;
    endtask

    // Counts cycles with busy high, starting from the current cycle.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; stop = 1'b0; restore = 1'b0; op = '0; dh = '0; dl = '0;

        add("mult_neg",   4'd1, 32'h0,        32'h0,        32'hFFFFFFFD, 32'h5,        5,  32'hFFFFFFFF, 32'hFFFFFFF1);
        add("div_neg",    4'd3, 32'h0,        32'h0,        32'hFFFFFFF9, 32'h2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        add("divu",       4'd4, 32'h0,        32'h0,        32'h7,        32'h2,        10, 32'h1,        32'h3);
        add("maddu",      4'd8, 32'h0,        32'hFFFFFFFF, 32'h1,        32'h1,        5,  32'h1,        32'h0);
        add("msub",       4'd9, 32'h1,        32'h0,        32'h1,        32'h1,        5,  32'h0,        32'hFFFFFFFF);
        add("multu_max",  4'd2, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h1);
        add("div_min_m1", 4'd3, 32'h0,        32'h0,        32'h80000000, 32'hFFFFFFFF, 10, 32'h0,        32'h80000000);
        add("div_pos_neg",4'd3, 32'h0,        32'h0,        32'h7,        32'hFFFFFFFE, 10, 32'h1,        32'hFFFFFFFD);
        add("div_zero",   4'd3, 32'h12345678, 32'h9ABCDEF0, 32'h5,        32'h0,        10, 32'h12345678, 32'h9ABCDEF0);
        add("msubu",      4'd10,32'h0,        32'h0,        32'h2,        32'h3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA);
        add("madd_neg",   4'd7, 32'h0,        32'h10,       32'hFFFFFFFF, 32'h3,        5,  32'h0,        32'hD);
        add("mult_min",   4'd1, 32'h0,        32'h0,        32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h0);
        add("mthi",       4'd5, 32'h1,        32'h2,        32'hDEADBEEF, 32'h0,        0,  32'hDEADBEEF, 32'h2);

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_hi", hi, '0);
        check("reset_lo", lo, '0);
        check("reset_invalid", invalid, 1'b0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            set_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_idle(n);
            check({vecs[i].name, "_cycles"}, n, vecs[i].cycles);
            check({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
            check({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
        end

        // Invalid op codes: flag is combinational, no state change.
        set_hilo(32'h55, 32'h66);
        op = 4'd11; #1;
        check("invalid_11", invalid, 1'b1);
        tick();
        check("invalid_busy", busy, 1'b0);
        check("invalid_hilo", {hi, lo}, {32'h55, 32'h66});
        op = 4'd15; #1;
        check("invalid_15", invalid, 1'b1);
        op = 4'd10; #1;
        check("valid_10", invalid, 1'b0);
        op = 4'd0;
        tick();

        // Stop on the 2nd busy cycle.
        set_hilo(32'hAAAA, 32'hBBBB);
        issue(4'd1, 32'd3, 32'd4);
        tick();
        stop = 1'b1; tick(); stop = 1'b0;
        check("stop2_busy", busy, 1'b0);
        check("stop2_hilo", {hi, lo}, {32'hAAAA, 32'hBBBB});
        repeat (5) tick();
        check("stop2_hilo_later", {hi, lo}, {32'hAAAA, 32'hBBBB});

        // Stop on the final busy cycle beats the commit.
        issue(4'd1, 32'd3, 32'd4);
        repeat (4) tick();
        check("stop5_still_busy", busy, 1'b1);
        stop = 1'b1; tick(); stop = 1'b0;
        check("stop5_busy", busy, 1'b0);
        check("stop5_hilo", {hi, lo}, {32'hAAAA, 32'hBBBB});

        // Stop in IDLE suppresses issue.
        op = 4'd1; dh = 32'd3; dl = 32'd4; stop = 1'b1; tick();
        op = 4'd0; stop = 1'b0;
        check("stop_idle_busy", busy, 1'b0);

        // MTLO then restore; restore beats MTHI.
        set_hilo(32'h11, 32'h22);
        issue(4'd6, 32'hAA, 32'h0);
        check("mtlo_lo", lo, 32'hAA);
        restore = 1'b1; tick(); restore = 1'b0;
        check("restore_hilo", {hi, lo}, {32'h11, 32'h22});
        restore = 1'b1; op = 4'd5; dh = 32'hFF; tick();
        restore = 1'b0; op = 4'd0; dh = '0;
        check("restore_mthi_hi", hi, 32'h11);

        // Restore in RUN aborts and rolls back.
        issue(4'd6, 32'h33, 32'h0);
        issue(4'd1, 32'd3, 32'd4);
        tick();
        restore = 1'b1; tick(); restore = 1'b0;
        check("restore_run_busy", busy, 1'b0);
        check("restore_run_hilo", {hi, lo}, {32'h11, 32'h22});

        // Ops presented while RUN are ignored; commit updates backup.
        set_hilo(32'h7, 32'h8);
        issue(4'd1, 32'd2, 32'd3);
        op = 4'd5; dh = 32'hFFFF; tick();
        op = 4'd0; dh = '0;
        wait_idle(n);
        check("run_ignore_cycles", n, 4);
        check("run_ignore_hilo", {hi, lo}, {32'h0, 32'h6});
        restore = 1'b1; tick(); restore = 1'b0;
        check("commit_backup", {hi, lo}, {32'h7, 32'h8});

        // Divide by zero leaves backup alone too.
        set_hilo(32'h1, 32'h2);
        issue(4'd6, 32'h3, 32'h0);
        issue(4'd3, 32'd5, 32'd0);
        wait_idle(n);
        check("dz_cycles", n, 10);
        check("dz_hilo", {hi, lo}, {32'h1, 32'h3});
        restore = 1'b1; tick(); restore = 1'b0;
        check("dz_backup", {hi, lo}, {32'h1, 32'h2});

        // Reset in the middle of a DIV.
        set_hilo(32'h5, 32'h6);
        issue(4'd3, 32'd100, 32'd3);
        repeat (3) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_hilo", {hi, lo}, 64'h0);
        restore = 1'b1; tick(); restore = 1'b0;
        check("rst_backup", {hi, lo}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
